// File: rtl/ica_conv_pkg.sv
// Shared types, constants and fixed-point helpers for the FastICA
// convergence checker. Data words are signed Q11.20 in 32 bits.
package ica_conv_pkg;

  localparam int DW            = 32;
  localparam int ACC_WIDTH_DEF = 36;

  localparam logic [DW-1:0] Q_ONE  = 32'h00100000;
  localparam logic [DW-1:0] Q_MAX  = 32'h7FFFFFFF;
  localparam logic [DW-1:0] Q_MIN  = 32'h80000000;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_MAC  = 2'd1;
  localparam state_t S_CMP  = 2'd2;
  localparam state_t S_DONE = 2'd3;

  // Clamp a sign-extended accumulator value into one data word.
  function automatic logic [DW-1:0] sat_q(input logic signed [63:0] a);
    logic [DW-1:0] r;
    if (a > $signed({32'h0, Q_MAX}))
      r = Q_MAX;
    else if (a < $signed({32'hFFFFFFFF, Q_MIN}))
      r = Q_MIN;
    else
      r = a[DW-1:0];
    return r;
  endfunction

  // Two's complement negation where -min clamps to max.
  function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] x);
    return (x == Q_MIN) ? Q_MAX : (~x + 1'b1);
  endfunction

  // Magnitude where |min| clamps to max.
  function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] x);
    return x[DW-1] ? neg_sat(x) : x;
  endfunction

endpackage

// File: rtl/ica_conv_check_5d_mac.sv
// Sequential Q-format MAC: acc += (a*b) >>> FRAC_WIDTH, one term per
// enabled cycle. The shifted product is truncated to ACC_WIDTH so the
// accumulator wraps modulo 2^ACC_WIDTH.
module ica_mac_q #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_WIDTH = 20,
  parameter int ACC_WIDTH  = 36
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]           term;

  // Full-width signed product, then arithmetic rescale back to Q format.
  always_comb begin
    prod = $signed(a) * $signed(b);
    term = ACC_WIDTH'(prod >>> FRAC_WIDTH);
  end

  // Accumulator register; clr takes priority over en.
  always_ff @(posedge clk) begin
    if (reset || clr)
      acc <= '0;
    else if (en)
      acc <= acc + term;
  end

endmodule

// File: rtl/ica_conv_check_5d.sv
// FastICA convergence checker: dot product of the new and previous
// normalised weight vectors, convergence / max-iteration flags and
// iteration count. Optional macro ICA_CONV_SIGN_ALIGN_EN stores the
// negated vector when the dot product is negative.
//
// state  | meaning
// IDLE   | waiting for start
// MAC    | accumulating one element product per cycle
// CMP    | saturate dot, evaluate convergence, bump iteration count
// DONE   | publish results, store vector, pulse done
module ica_conv_check_5d
  import ica_conv_pkg::*;
#(
  parameter int            DIMENSIONS = 5,
  parameter int            DATA_WIDTH = DW,
  parameter int            FRAC_WIDTH = 20,
  parameter int            ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter logic [DW-1:0] EPS        = 32'h00000400,
  parameter int            MAX_ITER   = 64,
  parameter int            ITER_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             start,
  input  logic [DIMENSIONS*DATA_WIDTH-1:0] w_new,
  output logic                             busy,
  output logic                             done,
  output logic                             converged,
  output logic                             max_iter_hit,
  output logic [ITER_WIDTH-1:0]            iter_count,
  output logic [DATA_WIDTH-1:0]            dot_out,
  output logic [DIMENSIONS*DATA_WIDTH-1:0] w_prev
);

  localparam int IDX_W = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIMENSIONS - 1);

  state_t                           state;
  logic [IDX_W-1:0]                 idx;
  logic [DIMENSIONS*DATA_WIDTH-1:0] w_cur;
  logic [DIMENSIONS*DATA_WIDTH-1:0] w_store;
  logic                             prev_valid;
  logic [DATA_WIDTH-1:0]            dot_q;
  logic                             conv_q;
  logic                             mit_q;

  logic [ACC_WIDTH-1:0]   acc;
  logic                   mac_clr;
  logic                   mac_en;
  logic signed [63:0]     acc_ext;
  logic [DATA_WIDTH-1:0]  dot_c;
  logic [DATA_WIDTH-1:0]  abs_c;
  logic signed [DATA_WIDTH:0] diff_c;
  logic                   conv_c;
  logic                   mit_c;
  logic [ITER_WIDTH-1:0]  iter_next;

  assign busy    = (state != S_IDLE);
  assign mac_clr = (state == S_IDLE) && start && !clear;
  assign mac_en  = (state == S_MAC);

  ica_mac_q #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (w_prev[idx*DATA_WIDTH +: DATA_WIDTH]),
    .b     (w_cur[idx*DATA_WIDTH +: DATA_WIDTH]),
    .acc   (acc)
  );

  // Convergence decision from the finished accumulator; a magnitude above
  // 1.0 yields a negative difference and therefore also counts as converged.
  always_comb begin
    acc_ext   = 64'($signed(acc));
    dot_c     = sat_q(acc_ext);
    abs_c     = abs_sat(dot_c);
    diff_c    = $signed({1'b0, Q_ONE}) - $signed({1'b0, abs_c});
    conv_c    = prev_valid && (diff_c <= $signed({1'b0, EPS}));
    iter_next = (&iter_count) ? iter_count : iter_count + 1'b1;
    mit_c     = !conv_c && (32'(iter_next) >= 32'(MAX_ITER));
  end

  // Vector kept for the next comparison, optionally sign-aligned.
  always_comb begin
    w_store = w_cur;
`ifdef ICA_CONV_SIGN_ALIGN_EN
    if (dot_q[DATA_WIDTH-1]) begin
      for (int i = 0; i < DIMENSIONS; i++)
        w_store[i*DATA_WIDTH +: DATA_WIDTH] = neg_sat(w_cur[i*DATA_WIDTH +: DATA_WIDTH]);
    end
`endif
  end

  // Sequencer, counters and result/vector storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      w_cur        <= '0;
      w_prev       <= '0;
      prev_valid   <= 1'b0;
      dot_q        <= '0;
      conv_q       <= 1'b0;
      mit_q        <= 1'b0;
      done         <= 1'b0;
      converged    <= 1'b0;
      max_iter_hit <= 1'b0;
      iter_count   <= '0;
      dot_out      <= '0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        // Abort any run; the stored vector stays but is no longer trusted.
        state        <= S_IDLE;
        iter_count   <= '0;
        prev_valid   <= 1'b0;
        converged    <= 1'b0;
        max_iter_hit <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              w_cur <= w_new;
              idx   <= '0;
              state <= S_MAC;
            end
          end
          S_MAC: begin
            idx <= idx + 1'b1;
            if (idx == IDX_LAST)
              state <= S_CMP;
          end
          S_CMP: begin
            dot_q      <= dot_c;
            conv_q     <= conv_c;
            mit_q      <= mit_c;
            iter_count <= iter_next;
            state      <= S_DONE;
          end
          S_DONE: begin
            done         <= 1'b1;
            converged    <= conv_q;
            max_iter_hit <= mit_q;
            dot_out      <= dot_q;
            w_prev       <= w_store;
            prev_valid   <= 1'b1;
            state        <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ica_conv_check_5d.sv
module tb_ica_conv_check_5d;

  localparam int D    = 5;
  localparam int MAXI = 4;
`ifdef ICA_CONV_SIGN_ALIGN_EN
  localparam bit SA = 1'b1;
`else
  localparam bit SA = 1'b0;
`endif

  localparam logic [159:0] E0  = {128'h0, 32'h00100000};
  localparam logic [159:0] E1  = {96'h0, 32'h00100000, 32'h0};
  localparam logic [159:0] NE0 = {128'h0, 32'hFFF00000};
  localparam logic [159:0] TA  = {128'h0, 32'h000FFC00};
  localparam logic [159:0] TB  = {128'h0, 32'h000FFBFF};

  logic         clk = 1'b0;
  logic         reset, clear, start;
  logic [159:0] w_new;
  logic         busy, done, converged, max_iter_hit;
  logic [7:0]   iter_count;
  logic [31:0]  dot_out;
  logic [159:0] w_prev;

  always #5 clk = ~clk;

  ica_conv_check_5d #(.MAX_ITER(MAXI)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .start        (start),
    .w_new        (w_new),
    .busy         (busy),
    .done         (done),
    .converged    (converged),
    .max_iter_hit (max_iter_hit),
    .iter_count   (iter_count),
    .dot_out      (dot_out),
    .w_prev       (w_prev)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: whole-vector arithmetic from the behavioural rules.
  logic [159:0] m_prev;
  bit           m_pv, m_conv, m_mit;
  int           m_iter;
  logic [31:0]  m_dot;

  function automatic logic [31:0] m_neg(input logic [31:0] x);
    return (x == 32'h80000000) ? 32'h7FFFFFFF : -x;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pv = 0; m_conv = 0; m_mit = 0; m_iter = 0; m_dot = '0;
  endtask

  task automatic model_clear();
    m_pv = 0; m_conv = 0; m_mit = 0; m_iter = 0;
  endtask

  task automatic model_step(input logic [159:0] cur);
    longint s, a, lim, diff;
    logic [63:0] s_bits;
    logic [31:0] d, ab;
    s = 0;
    lim = 64'sd2147483647;
    for (int i = 0; i < D; i++)
      s += (longint'($signed(m_prev[i*32 +: 32])) * longint'($signed(cur[i*32 +: 32]))) >>> 20;
    s_bits = s;
    a = longint'($signed(s_bits[35:0]));
    if (a > lim) d = 32'h7FFFFFFF;
    else if (a < -lim - 1) d = 32'h80000000;
    else d = a[31:0];
    ab = (d == 32'h80000000) ? 32'h7FFFFFFF : (d[31] ? -d : d);
    diff = longint'(32'h00100000) - longint'(ab);
    m_conv = m_pv && (diff <= 1024);
    m_iter = (m_iter < 255) ? m_iter + 1 : 255;
    m_mit  = !m_conv && (m_iter >= MAXI);
    m_dot  = d;
    if (SA && d[31]) begin
      for (int i = 0; i < D; i++) m_prev[i*32 +: 32] = m_neg(cur[i*32 +: 32]);
    end else begin
      m_prev = cur;
    end
    m_pv = 1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dot"},  160'(dot_out),      160'(m_dot));
    chk({tag, ".conv"}, 160'(converged),    160'(m_conv));
    chk({tag, ".mit"},  160'(max_iter_hit), 160'(m_mit));
    chk({tag, ".iter"}, 160'(iter_count),   160'(m_iter));
    chk({tag, ".wp"},   w_prev,             m_prev);
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  // Pulse start and count edges from the sampling edge to done (-1 = none).
  task automatic run_vec(input logic [159:0] w, output int lat);
    @(negedge clk); w_new = w; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
  endtask

  function automatic logic [159:0] rand_vec(input int mode);
    logic [159:0] v;
    int k;
    k = $urandom_range(0, 4);
    for (int i = 0; i < D; i++) begin
      case (mode)
        0: v[i*32 +: 32] = $urandom;
        1: v[i*32 +: 32] = 32'($urandom_range(0, 1048576)) - 32'h00080000;
        2: v[i*32 +: 32] = ((i == k) ? (($urandom_range(0, 1) == 1) ? 32'hFFF00000 : 32'h00100000) : 32'h0)
                           + 32'($urandom_range(0, 2048)) - 32'd1024;
        default: v[i*32 +: 32] = (i == 0) ? 32'h00100000 : 32'h0;
      endcase
    end
    return v;
  endfunction

  typedef struct {
    logic         do_clear;
    logic [159:0] w;
    logic [31:0]  dot;
    logic         conv;
    logic         mit;
    logic [7:0]   iter;
    logic [159:0] wp;
  } vec_t;

  vec_t tv[14];

  function automatic vec_t mk(input logic c, input logic [159:0] w, input logic [31:0] dt,
                              input logic cv, input logic mi, input logic [7:0] it,
                              input logic [159:0] wp);
    vec_t r;
    r.do_clear = c; r.w = w; r.dot = dt; r.conv = cv; r.mit = mi; r.iter = it; r.wp = wp;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, ndone;
    bit got;

    tv[0]  = mk(1, E0,  32'h00000000, 0, 0, 1, E0);
    tv[1]  = mk(0, E0,  32'h00100000, 1, 0, 2, E0);
    tv[2]  = mk(0, E1,  32'h00000000, 0, 0, 3, E1);
    tv[3]  = mk(1, E0,  32'h00000000, 0, 0, 1, E0);
    tv[4]  = mk(0, NE0, 32'hFFF00000, 1, 0, 2, SA ? E0 : NE0);
    tv[5]  = mk(1, E1,  32'h00000000, 0, 0, 1, E1);
    tv[6]  = mk(0, E0,  32'h00000000, 0, 0, 2, E0);
    tv[7]  = mk(0, TA,  32'h000FFC00, 1, 0, 3, TA);
    tv[8]  = mk(0, E0,  32'h000FFC00, 1, 0, 4, E0);
    tv[9]  = mk(0, TB,  32'h000FFBFF, 0, 1, 5, TB);
    tv[10] = mk(1, E0,  32'h000FFBFF, 0, 0, 1, E0);
    tv[11] = mk(0, E1,  32'h00000000, 0, 0, 2, E1);
    tv[12] = mk(0, E0,  32'h00000000, 0, 0, 3, E0);
    tv[13] = mk(0, E1,  32'h00000000, 0, 1, 4, E1);

    reset = 1'b1; clear = 1'b0; start = 1'b0; w_new = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    chk("rst.busy", 160'(busy), 0);
    chk("rst.done", 160'(done), 0);
    chk("rst.conv", 160'(converged), 0);
    chk("rst.mit",  160'(max_iter_hit), 0);
    chk("rst.iter", 160'(iter_count), 0);
    chk("rst.dot",  160'(dot_out), 0);
    chk("rst.wp",   w_prev, 0);

    // Directed table
    for (int t = 0; t < 14; t++) begin
      if (tv[t].do_clear) do_clear();
      run_vec(tv[t].w, lat);
      chk($sformatf("tv%0d.lat", t),  160'(lat), 160'(7));
      chk($sformatf("tv%0d.dot", t),  160'(dot_out), 160'(tv[t].dot));
      chk($sformatf("tv%0d.conv", t), 160'(converged), 160'(tv[t].conv));
      chk($sformatf("tv%0d.mit", t),  160'(max_iter_hit), 160'(tv[t].mit));
      chk($sformatf("tv%0d.iter", t), 160'(iter_count), 160'(tv[t].iter));
      chk($sformatf("tv%0d.wp", t),   w_prev, tv[t].wp);
      @(posedge clk); #1;
      chk($sformatf("tv%0d.pulse", t), 160'(done), 0);
    end

    // Clear during MAC aborts the run
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    do_clear(); model_clear();
    run_vec(E0, lat); model_step(E0);
    check_model("abort.prime");
    @(negedge clk); w_new = E1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
    got = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("abort.no_done", 160'(got), 0);
    chk("abort.iter", 160'(iter_count), 0);
    chk("abort.conv", 160'(converged), 0);
    chk("abort.busy", 160'(busy), 0);
    run_vec(E0, lat); model_step(E0);
    chk("abort.lat", 160'(lat), 160'(7));
    check_model("abort.first");

    // Start while busy is dropped
    @(negedge clk); w_new = E1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); w_new = E0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    model_step(E1);
    chk("busy.ndone", 160'(ndone), 160'(1));
    check_model("busy");

    // Reset in the middle of MAC
    @(negedge clk); w_new = E0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    chk("midrst.busy", 160'(busy), 0);
    chk("midrst.iter", 160'(iter_count), 0);
    chk("midrst.dot",  160'(dot_out), 0);
    chk("midrst.wp",   w_prev, 0);
    got = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("midrst.no_done", 160'(got), 0);

    // Randomised run against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [159:0] v;
      if ($urandom_range(0, 7) == 0) begin do_clear(); model_clear(); end
      v = rand_vec(int'($urandom_range(0, 3)));
      run_vec(v, lat);
      model_step(v);
      chk($sformatf("rnd%0d.lat", n), 160'(lat), 160'(7));
      check_model($sformatf("rnd%0d", n));
    end

    // Iteration counter saturates at all-ones
    do_clear(); model_clear();
    for (int n = 0; n < 258; n++) begin
      run_vec(E0, lat);
      model_step(E0);
    end
    chk("sat.iter", 160'(iter_count), 160'(255));
    check_model("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ica_conv_check_5d.md
Name: ica_conv_check_5d

Overview:
- Downstream neighbour of the 5-D CORDIC normaliser in the FastICA loop. Consumes each normalised weight vector and decides whether the fixed-point iteration has converged.
- Computes the Q11.20 dot product of the new and previous normalised vectors using one sequential MAC. Converged when 1.0 - |dot| <= EPS.
- Tracks the iteration count, flags max-iteration exhaustion, and stores the vector for the next comparison.

Parameters:
- DIMENSIONS, 5, vector length
- DATA_WIDTH, 32, element width (signed Q11.20)
- FRAC_WIDTH, 20, fractional bits
- ACC_WIDTH, 36, dot-product accumulator width (signed)
- EPS, 32'h00000400, convergence tolerance (~0.00098)
- MAX_ITER, 64, iteration limit per component
- ITER_WIDTH, 8, iteration counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  start new component: zero iteration count, invalidate stored vector
- start  in  1  pulse: w_new valid (driven by normaliser done)
- w_new  in  DIMENSIONS*DATA_WIDTH  new normalised vector; element i at [i*DW +: DW]
- busy  out  1  high from MAC through DONE
- done  out  1  one-cycle pulse, results valid
- converged  out  1  convergence flag; held until next done, clear or reset
- max_iter_hit  out  1  iteration limit reached without convergence; held like converged
- iter_count  out  ITER_WIDTH  completed iterations since clear
- dot_out  out  DATA_WIDTH  last dot product (signed Q11.20, saturated)
- w_prev  out  DIMENSIONS*DATA_WIDTH  stored vector for the next comparison

Behaviour:
- Reset: synchronous, active-high. On reset every output, accumulator, index, stored vector and prev_valid go to 0; state goes to IDLE.
- States:
  - IDLE: on start (and clear low), latch w_new into w_cur, acc<=0, idx<=0, go to MAC.
  - MAC: each cycle, acc += (w_prev[idx]*w_cur[idx]) >>> FRAC_WIDTH. The product is 2*DW signed and the shift is arithmetic. idx++. After idx==DIMENSIONS-1, go to CMP. MAC takes exactly DIMENSIONS cycles.
  - CMP:
    - dot = acc saturated to DATA_WIDTH; abs_dot = |dot|, with the most negative value saturating to the positive maximum.
    - If prev_valid, conv = (32'h00100000 - abs_dot) <= EPS, computed signed, so abs_dot > 1.0 also counts as converged. If not prev_valid, conv = 0.
    - iter_count increments, saturating at all-ones.
    - Go to DONE.
  - DONE: done=1 for one cycle. Update converged, max_iter_hit, dot_out. w_prev<=w_cur, prev_valid<=1. Go to IDLE.
- max_iter_hit = !conv && (iter_count after increment) >= MAX_ITER.
- Latency: done is high in the cycle following the (DIMENSIONS+2)th rising edge after the edge that samples start (7 edges for D=5).
- Throughput: one vector every DIMENSIONS+3 cycles; busy is low only in IDLE.
- start while busy: ignored, with no queueing.
- clear:
  - In any state, return to IDLE the next cycle. iter_count, prev_valid, converged and max_iter_hit go to 0; no done is generated.
  - w_prev is retained but marked invalid.
- clear and start in the same cycle: clear wins, start dropped.
- First vector after clear: never converged; it only primes w_prev.
- Reset asserted mid-operation: the run is aborted immediately as for reset; no done.

Optional Feature:
- Macro: ICA_CONV_SIGN_ALIGN_EN.
- When defined: if dot < 0 in CMP, w_prev is stored as the element-wise negation of w_cur, with -min saturating to max. This keeps consecutive iterates sign-aligned; converged is unaffected.
- When undefined: w_prev is stored as w_cur unmodified.

Decomposition:
- Package ica_conv_pkg:
  - state enum (IDLE, MAC, CMP, DONE)
  - Q_ONE = 32'h00100000
  - ACC_WIDTH default
  - saturate/abs helper functions
- One sub-module, ica_mac_q: signed multiply, arithmetic shift by FRAC_WIDTH, accumulate with clear and enable.
- The FSM, counters and storage live in the top level.

Test Plan:
- Identical vectors: clear, then start with e0=(0x00100000,0,0,0,0) → done, converged=0, iter_count=1. Start e0 again → dot_out=0x00100000, converged=1, iter_count=2, done 7 edges after start.
- Orthogonal: after priming with e0, start e1=(0,0x00100000,0,0,0) → dot_out=0, converged=0.
- Opposite sign: prime with e0, start -e0 (0xFFF00000) → dot_out=0xFFF00000, converged=1. With ICA_CONV_SIGN_ALIGN_EN, w_prev element0 = 0x00100000; without it, w_prev element0 = 0xFFF00000.
- Tolerance edge:
  - prime e0, then (0x000FFC00,0,...) → converged=1 (diff=EPS)
  - prime e0, then (0x000FFBFF,0,...) → converged=0
- Max-iteration flag: MAX_ITER=4, alternate e0/e1 four times → the 4th done gives max_iter_hit=1, converged=0.
- Abort and protocol:
  - clear during MAC → no done, iter_count=0, next vector treated as first
  - start while busy → ignored
  - reset mid-MAC → all outputs 0
